ecc_scrub_ctrl: RTL and testbench

//  Background scrubber for the ECC-protected FIFO storage RAM (39-bit words: {ecc[6:0],data[31:0]}).

---
 rtl/ecc_scrub_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl -- background scrubber for the ECC-protected FIFO storage RAM.
//
// Walks the RAM one word at a time, using only cycles where the FIFO leaves
// the port free. Each word is read, checked by the external SEC-DED decoder,
// and rewritten re-encoded when the decoder corrected a single-bit error.
// Word layout is {ecc[6:0], data[31:0]}; ecc = {p[5:0], p0}.
//
// Optional feature (compile-time macro): SCRUB_DBE_HALT_EN
//   defined   : a double-bit error parks the scrubber in IDLE with the
//               pointer on the failing word; it restarts only after scrub_en_i
//               has been low for at least one cycle.
//   undefined : double-bit errors are counted and scrubbing carries on.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   scrub_en_i          enable background scrubbing
//   fifo_busy_i         FIFO owns the RAM port this cycle
//   fifo_wr_en_i/addr   FIFO write strobe/address (write-conflict detection)
//   mem_req_o/we/addr   scrubber RAM access, 1=write, address = scrub pointer
//   mem_wdata_o         {encode(corrected data), corrected data}
//   mem_rdata_i         RAM read data (consumed by the external decoder only)
//   dec_data/sbe/dbe_i  decoder result for the word read the previous cycle
//   sbe_cnt_o/dbe_cnt_o saturating error counters
//   pass_done_o         one-cycle pulse when the pointer wraps to 0
//   busy_o              scrubber not idle
module ecc_scrub_ctrl #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int INTERVAL = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scrub_en_i,
  input  logic             fifo_busy_i,
  input  logic             fifo_wr_en_i,
  input  logic [AW-1:0]    fifo_wr_addr_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [38:0]      mem_wdata_o,
  input  logic [38:0]      mem_rdata_i,
  input  logic [31:0]      dec_data_i,
  input  logic             dec_sbe_i,
  input  logic             dec_dbe_i,
  output logic [CNT_W-1:0] sbe_cnt_o,
  output logic [CNT_W-1:0] dbe_cnt_o,
  output logic             pass_done_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_CHK, S_WB, S_NEXT} state_e;

  localparam int               WAIT_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(INTERVAL - 1);
  localparam logic [AW-1:0]    LAST      = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       fix_q;
  logic [CNT_W-1:0]  sbe_q, sbe_d, dbe_q, dbe_d;
  logic              pass_q;
  logic              conflict;
`ifdef SCRUB_DBE_HALT_EN
  logic              halted_q;
`endif

  // Hamming(38,32) plus overall parity. Codeword positions 1..38; powers of
  // two hold p[5:0], data bits fill the remaining positions in order.
  function automatic logic [6:0] ecc_encode(input logic [31:0] d);
    logic [38:1] cw;
    logic [5:0]  p;
    int          di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    p = '0;
    for (int i = 0; i < 6; i++)
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> i) & 1) != 0) p[i] = p[i] ^ cw[pos];
    return {p, (^d) ^ (^p)};
  endfunction

  // Any FIFO write to the word in flight makes the latched correction stale.
  assign conflict = fifo_wr_en_i && (fifo_wr_addr_i == ptr_q);

  assign ptr_d = (ptr_q == LAST)    ? '0    : ptr_q + 1'b1;
  assign sbe_d = (sbe_q == CNT_MAX) ? sbe_q : sbe_q + 1'b1;
  assign dbe_d = (dbe_q == CNT_MAX) ? dbe_q : dbe_q + 1'b1;

  // Gated by rst_i so a reset landing in WB can never let a write through.
  assign mem_req_o   = !rst_i && !fifo_busy_i &&
                       ((state_q == S_RD) || ((state_q == S_WB) && !conflict));
  assign mem_we_o    = !rst_i && (state_q == S_WB);
  assign mem_addr_o  = ptr_q;
  assign mem_wdata_o = {ecc_encode(fix_q), fix_q};

  assign sbe_cnt_o   = sbe_q;
  assign dbe_cnt_o   = dbe_q;
  assign pass_done_o = pass_q;
  assign busy_o      = (state_q != S_IDLE);

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      wait_q   <= '0;
      fix_q    <= '0;
      sbe_q    <= '0;
      dbe_q    <= '0;
      pass_q   <= 1'b0;
`ifdef SCRUB_DBE_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pass_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef SCRUB_DBE_HALT_EN
          if (!scrub_en_i) halted_q <= 1'b0;
          if (scrub_en_i && !halted_q) begin
`else
          if (scrub_en_i) begin
`endif
            wait_q  <= WAIT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!scrub_en_i)       state_q <= S_IDLE;
          else if (wait_q == '0) state_q <= S_RD;
          else                   wait_q  <= wait_q - 1'b1;
        end
        S_RD: if (!fifo_busy_i) state_q <= S_CHK;
        S_CHK: begin
          // dbe wins when the decoder flags both
          if (dec_dbe_i) begin
            dbe_q <= dbe_d;
`ifdef SCRUB_DBE_HALT_EN
            halted_q <= 1'b1;
            state_q  <= S_IDLE;
`else
            state_q  <= S_NEXT;
`endif
          end else if (dec_sbe_i) begin
            sbe_q   <= sbe_d;
            fix_q   <= dec_data_i;
            state_q <= conflict ? S_NEXT : S_WB;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_WB: if (conflict || !fifo_busy_i) state_q <= S_NEXT;
        S_NEXT: begin
          ptr_q  <= ptr_d;
          pass_q <= (ptr_q == LAST);
          if (scrub_en_i) begin
            wait_q  <= WAIT_LOAD;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl (DEPTH=16, INTERVAL=4).
// The bench plays RAM + SEC-DED decoder, keeps a behavioural model of the
// scrubber and compares every DUT output against it each cycle.
module tb_ecc_scrub_ctrl;
  localparam int DEPTH = 16, AW = 4, INTERVAL = 4, CNT_W = 8;
`ifdef SCRUB_DBE_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_RD = 2, PH_CHK = 3, PH_WB = 4, PH_NEXT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, scrub_en = 1'b0, fifo_busy = 1'b0, fifo_wr_en = 1'b0;
  logic [AW-1:0] fifo_wr_addr = '0;
  logic mem_req, mem_we, pass_done, busy;
  logic [AW-1:0] mem_addr;
  logic [38:0] mem_wdata, mem_rdata = '0;
  logic [31:0] dec_data = '0;
  logic dec_sbe = 1'b0, dec_dbe = 1'b0;
  logic [CNT_W-1:0] sbe_cnt, dbe_cnt;

  ecc_scrub_ctrl #(.DEPTH(DEPTH), .AW(AW), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .scrub_en_i(scrub_en), .fifo_busy_i(fifo_busy),
    .fifo_wr_en_i(fifo_wr_en), .fifo_wr_addr_i(fifo_wr_addr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .dec_data_i(dec_data),
    .dec_sbe_i(dec_sbe), .dec_dbe_i(dec_dbe), .sbe_cnt_o(sbe_cnt),
    .dbe_cnt_o(dbe_cnt), .pass_done_o(pass_done), .busy_o(busy));

  int checks = 0, failures = 0, cyc = 0;

  // RAM contents and injected faults: 0 clean, 1 single-bit, 2 double-bit
  logic [31:0] ram_data [DEPTH];
  int          fault    [DEPTH];
  int          fbit     [DEPTH];
  bit          sticky_sbe = 1'b0;
  int          sticky_rds = 0;

  // event log
  int rd_cnt = 0, wr_cnt = 0, pd_cnt = 0, viol = 0, last_wr_addr = -1;
  logic [38:0] last_wr_data = '0;
  int rd_at [DEPTH];
  int rd_log [$];

  // behavioural model
  bit          m_valid = 1'b0, m_pd = 1'b0, m_halt = 1'b0;
  int          m_phase = PH_IDLE, m_ptr = 0, m_gap = 0, m_sbe = 0, m_dbe = 0;
  logic [31:0] m_fix = '0;

  // parity masks over the data word, derived from the codeword position map
  logic [31:0] pmask [6];

  task automatic build_masks();
    int di;
    di = 0;
    for (int i = 0; i < 6; i++) pmask[i] = '0;
    for (int pos = 1; pos <= 38; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
        for (int i = 0; i < 6; i++) if ((pos & (1 << i)) != 0) pmask[i][di] = 1'b1;
        di++;
      end
    end
  endtask

  function automatic logic [6:0] tb_enc(input logic [31:0] d);
    logic [5:0] p;
    for (int i = 0; i < 6; i++) p[i] = ^(d & pmask[i]);
    return {p, (^d) ^ (^p)};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Per-cycle: compare outputs, advance model, act as RAM/decoder.
  task automatic model_and_check();
    bit exp_req, conf, nxt_pd;
    logic [31:0] d, flip;
    int a, kind;
    conf = fifo_wr_en && (int'(fifo_wr_addr) == m_ptr);
    exp_req = 1'b0;
    if (!rst && m_phase == PH_RD) exp_req = !fifo_busy;
    if (!rst && m_phase == PH_WB) exp_req = !fifo_busy && !conf;
    cmp("mem_req", 64'(mem_req), 64'(exp_req));
    if (exp_req) begin
      cmp("mem_addr", 64'(mem_addr), 64'(m_ptr));
      cmp("mem_we", 64'(mem_we), 64'(m_phase == PH_WB));
      if (m_phase == PH_WB) cmp("mem_wdata", 64'(mem_wdata), 64'({tb_enc(m_fix), m_fix}));
    end
    if (m_valid) begin
      cmp("busy", 64'(busy), 64'(m_phase != PH_IDLE));
      cmp("pass_done", 64'(pass_done), 64'(m_pd));
      cmp("sbe_cnt", 64'(sbe_cnt), 64'(m_sbe));
      cmp("dbe_cnt", 64'(dbe_cnt), 64'(m_dbe));
    end
    if (fifo_busy && mem_req) viol++;
    if (pass_done) pd_cnt++;

    // model advance
    if (rst) begin
      m_valid = 1'b1; m_phase = PH_IDLE; m_ptr = 0; m_gap = 0;
      m_sbe = 0; m_dbe = 0; m_pd = 1'b0; m_halt = 1'b0;
    end else begin
      nxt_pd = 1'b0;
      case (m_phase)
        PH_IDLE: begin
          if (HALT && !scrub_en) m_halt = 1'b0;
          else if (scrub_en && !m_halt) begin m_phase = PH_WAIT; m_gap = INTERVAL - 1; end
        end
        PH_WAIT: begin
          if (!scrub_en) m_phase = PH_IDLE;
          else if (m_gap == 0) m_phase = PH_RD;
          else m_gap--;
        end
        PH_RD: if (!fifo_busy) m_phase = PH_CHK;
        PH_CHK: begin
          if (dec_dbe) begin
            m_dbe = sat(m_dbe);
            if (HALT) begin m_halt = 1'b1; m_phase = PH_IDLE; end
            else m_phase = PH_NEXT;
          end else if (dec_sbe) begin
            m_sbe = sat(m_sbe);
            m_fix = dec_data;
            m_phase = conf ? PH_NEXT : PH_WB;
          end else m_phase = PH_NEXT;
        end
        PH_WB: if (conf || !fifo_busy) m_phase = PH_NEXT;
        default: begin
          nxt_pd = (m_ptr == DEPTH - 1);
          m_ptr = (m_ptr + 1) % DEPTH;
          if (scrub_en) begin m_phase = PH_WAIT; m_gap = INTERVAL - 1; end
          else m_phase = PH_IDLE;
        end
      endcase
      m_pd = nxt_pd;
    end

    // RAM + decoder
    a = int'(mem_addr);
    if (mem_req && !mem_we) begin
      rd_cnt++;
      rd_at[a] = cyc;
      rd_log.push_back(a);
      d = ram_data[a];
      kind = sticky_sbe ? 1 : fault[a];
      if (sticky_sbe) sticky_rds++;
      flip = '0;
      if (kind >= 1) flip[fbit[a]] = 1'b1;
      if (kind == 2) flip[(fbit[a] + 7) % 32] = 1'b1;
      mem_rdata = {tb_enc(d), d ^ flip};
      dec_data  = (kind == 2) ? (d ^ flip) : d;
      dec_sbe   = (kind == 1);
      dec_dbe   = (kind == 2);
    end
    if (mem_req && mem_we) begin
      wr_cnt++;
      last_wr_addr = a;
      last_wr_data = mem_wdata;
      cmp("wb_fresh", 64'(mem_wdata), 64'({tb_enc(ram_data[a]), ram_data[a]}));
      fault[a] = 0;
    end
    if (fifo_wr_en) begin
      ram_data[fifo_wr_addr] = $urandom;
      fault[fifo_wr_addr] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rd(input int ptr, input string name);
    int n;
    n = 0;
    while (!(m_phase == PH_RD && m_ptr == ptr) && n < 600) begin step(); n++; end
    if (!(m_phase == PH_RD && m_ptr == ptr)) expire(name);
  endtask

  task automatic wait_pd(input int target, input string name);
    int n;
    n = 0;
    while (pd_cnt < target && n < 600) begin step(); n++; end
    if (pd_cnt < target) expire(name);
  endtask

  initial begin
    int n, w0, s0;
    build_masks();
    for (int i = 0; i < DEPTH; i++) begin
      ram_data[i] = $urandom; fault[i] = 0; fbit[i] = $urandom_range(0, 31); rd_at[i] = 0;
    end
    // hand-computed encodings pin the model's code
    cmp("enc_zero", 64'(tb_enc(32'h0)), 64'h00);
    cmp("enc_bit0", 64'(tb_enc(32'h1)), 64'h07);
    cmp("enc_bit1", 64'(tb_enc(32'h2)), 64'h0B);
    cmp("enc_bit31", 64'(tb_enc(32'h8000_0000)), 64'h4C);

    step(); step();
    rst = 1'b0;
    cmp("rst_busy", 64'(busy), 64'h0);
    cmp("rst_req", 64'(mem_req), 64'h0);
    cmp("rst_we", 64'(mem_we), 64'h0);
    cmp("rst_pd", 64'(pass_done), 64'h0);
    cmp("rst_sbe", 64'(sbe_cnt), 64'h0);
    cmp("rst_dbe", 64'(dbe_cnt), 64'h0);

    // 1: clean pass
    scrub_en = 1'b1;
    wait_pd(1, "t1_pass");
    cmp("t1_reads", 64'(rd_cnt), 64'd16);
    cmp("t1_writes", 64'(wr_cnt), 64'd0);
    for (int i = 0; i < 16 && i < rd_log.size(); i++) cmp("t1_order", 64'(rd_log[i]), 64'(i));
    cmp("t1_period", 64'(rd_at[1] - rd_at[0]), 64'd7);
    cmp("t1_sbe", 64'(sbe_cnt), 64'd0);

    // 2: sbe at 5, bit 3
    fault[5] = 1; fbit[5] = 3;
    wait_pd(2, "t2_pass");
    cmp("t2_sbe", 64'(sbe_cnt), 64'd1);
    cmp("t2_writes", 64'(wr_cnt), 64'd1);
    cmp("t2_wr_addr", 64'(last_wr_addr), 64'd5);
    cmp("t2_wr_data", 64'(last_wr_data), 64'({tb_enc(ram_data[5]), ram_data[5]}));
    cmp("t2_period", 64'(rd_at[6] - rd_at[5]), 64'd8);

    // 3: dbe at 9
    fault[9] = 2; fbit[9] = 0;
    if (HALT) begin
      n = 0;
      while (m_dbe < 1 && n < 600) begin step(); n++; end
      if (m_dbe < 1) expire("t3_dbe");
      for (int i = 0; i < 10; i++) step();
      cmp("t3_halt_busy", 64'(busy), 64'h0);
      cmp("t3_halt_ptr", 64'(mem_addr), 64'd9);
      fault[9] = 0;
      scrub_en = 1'b0; step(); scrub_en = 1'b1;
    end
    wait_pd(3, "t3_pass");
    cmp("t3_dbe", 64'(dbe_cnt), 64'd1);
    cmp("t3_writes", 64'(wr_cnt), 64'd1);
    fault[9] = 0;

    // 4: FIFO holds the port in RD and in WB
    fault[2] = 1;
    wait_rd(2, "t4_rd");
    fifo_busy = 1'b1;
    for (int i = 0; i < 10; i++) step();
    fifo_busy = 1'b0;
    n = rd_cnt; step();
    cmp("t4_rd_first_free", 64'(rd_cnt - n), 64'd1);
    n = 0;
    while (m_phase != PH_WB && n < 5) begin step(); n++; end
    if (m_phase != PH_WB) expire("t4_wb");
    fifo_busy = 1'b1;
    for (int i = 0; i < 10; i++) step();
    fifo_busy = 1'b0;
    n = wr_cnt; step();
    cmp("t4_wr_first_free", 64'(wr_cnt - n), 64'd1);
    cmp("t4_wr_addr", 64'(last_wr_addr), 64'd2);
    cmp("t4_no_req_busy", 64'(viol), 64'd0);

    // 5: FIFO writes the word under check
    fault[3] = 1;
    wait_rd(3, "t5_rd");
    step();
    fifo_busy = 1'b1; fifo_wr_en = 1'b1; fifo_wr_addr = 4'd3;
    step();
    fifo_busy = 1'b0; fifo_wr_en = 1'b0;
    step();
    cmp("t5_ptr", 64'(mem_addr), 64'd4);
    cmp("t5_sbe", 64'(sbe_cnt), 64'd3);
    cmp("t5_writes", 64'(wr_cnt), 64'd2);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      scrub_en = ($urandom_range(0, 99) < 97);
      fifo_busy = ($urandom_range(0, 99) < 30);
      fifo_wr_en = fifo_busy && $urandom_range(0, 1) == 1;
      fifo_wr_addr = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 99) < 4) begin
        n = $urandom_range(0, DEPTH - 1);
        fault[n] = ($urandom_range(0, 9) == 0) ? 2 : 1;
        fbit[n] = $urandom_range(0, 31);
      end
      step();
    end
    fifo_busy = 1'b0; fifo_wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) fault[i] = 0;
    cmp("rand_no_req_busy", 64'(viol), 64'd0);

    // 6: reset during writeback, then saturation
    scrub_en = 1'b0; step(); scrub_en = 1'b1;
    fault[7] = 1;
    n = 0;
    while (!(m_phase == PH_WB && m_ptr == 7) && n < 800) begin step(); n++; end
    if (!(m_phase == PH_WB && m_ptr == 7)) expire("t6_wb");
    w0 = wr_cnt;
    rst = 1'b1; step(); rst = 1'b0;
    cmp("t6_no_write", 64'(wr_cnt), 64'(w0));
    cmp("t6_busy", 64'(busy), 64'h0);
    cmp("t6_req", 64'(mem_req), 64'h0);
    cmp("t6_ptr", 64'(mem_addr), 64'h0);
    cmp("t6_sbe", 64'(sbe_cnt), 64'h0);
    cmp("t6_dbe", 64'(dbe_cnt), 64'h0);
    cmp("t6_pd", 64'(pass_done), 64'h0);
    sticky_sbe = 1'b1;
    s0 = 0;
    while (sticky_rds < 300 && s0 < 4000) begin step(); s0++; end
    if (sticky_rds < 300) expire("t6_sat");
    step(); step();
    sticky_sbe = 1'b0;
    cmp("t6_sbe_sat", 64'(sbe_cnt), 64'd255);
    cmp("t6_dbe_zero", 64'(dbe_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
